// File: rtl/collector_pkg.sv
// Shared types and defaults for the child result collector and its round-robin arbiter.
package collector_pkg;

    localparam int unsigned DEF_N_CHILD    = 15;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_CNT_W      = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_N_CHILD);

    // Default-sized word; the collector declares its own copy sized by its parameters.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_IDX_W-1:0]  idx;
    } collector_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a rotating pointer that moves past each winner.
module rr_arbiter #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         grant_en,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr_q, ptr_d;
    logic         found;

    always_comb begin
        int unsigned c;
        c         = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c = 32'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (!found && req[W'(c)]) begin
                found     = 1'b1;
                grant_idx = W'(c);
            end
        end
    end

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (grant_en && found) begin
            grant[grant_idx] = 1'b1;
            ptr_d = (grant_idx == W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/child_result_collector.sv
// Collects result words from child instances via round-robin arbitration into a small
// output FIFO, tagging each word with the index of the child that produced it.
module child_result_collector
    import collector_pkg::*;
#(
    parameter  int unsigned N_CHILD    = DEF_N_CHILD,
    parameter  int unsigned DATA_W     = DEF_DATA_W,
    parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int unsigned CNT_W      = DEF_CNT_W,
    localparam int unsigned IDX_W      = idx_width(N_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CHILD-1:0]          child_valid,
    input  logic [N_CHILD*DATA_W-1:0]   child_data,
    output logic [N_CHILD-1:0]          child_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]            xfer_count
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = ADDR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } word_t;

    logic [N_CHILD-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_en;
    logic               push, pop;
    word_t              in_word;

    word_t              mem_q [FIFO_DEPTH];
    word_t              mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]  count_q, count_d;
    logic [CNT_W-1:0]   xfer_q, xfer_d;

    // Acceptance depends only on registered occupancy, never on out_ready.
    assign grant_en = (count_q < CNT_FW'(FIFO_DEPTH));

    rr_arbiter #(.N(N_CHILD)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (child_valid),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        int unsigned base;
        base         = 32'(grant_idx) * DATA_W;
        in_word.data = child_data[base +: DATA_W];
        in_word.idx  = grant_idx;
        push         = |grant;
        pop          = (count_q != '0) && out_ready;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        xfer_d = (push && (xfer_q != '1)) ? xfer_q + 1'b1 : xfer_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            xfer_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            xfer_q   <= xfer_d;
        end
    end

    assign child_ready = grant;
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q].data;
    assign out_idx     = mem_q[rd_ptr_q].idx;
    assign fifo_count  = count_q;
    assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_child_result_collector.sv
// Directed bench for child_result_collector with a reference arbitration model and word scoreboard.
module tb_child_result_collector;

    localparam int unsigned N     = 15;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    child_valid, child_ready;
    logic [N*DW-1:0] child_data;
    logic            out_valid, out_ready;
    logic [DW-1:0]   out_data;
    logic [3:0]      out_idx;
    logic [2:0]      fifo_count;
    logic [15:0]     xfer_count;

    logic [N-1:0]    s_valid, s_ready;
    logic [N*DW-1:0] s_data;
    logic            s_out_valid, s_out_ready;
    logic [DW-1:0]   s_out_data;
    logic [3:0]      s_out_idx;
    logic [2:0]      s_fifo_count;
    logic [3:0]      s_xfer;

    child_result_collector #(.N_CHILD(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
        .child_ready(child_ready), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_ready(out_ready), .fifo_count(fifo_count),
        .xfer_count(xfer_count)
    );

    child_result_collector #(.N_CHILD(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .child_valid(s_valid), .child_data(s_data),
        .child_ready(s_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_idx(s_out_idx), .out_ready(s_out_ready), .fifo_count(s_fifo_count),
        .xfer_count(s_xfer)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    idx;
    } exp_t;

    exp_t          sb[$];
    int unsigned   pending[N];
    logic [DW-1:0] cdata[N];
    int unsigned   m_ptr;
    logic [15:0]   m_xfer;
    int            pass_cnt  = 0;
    int            total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            child_valid[i]          = (pending[i] != 0);
            child_data[i*DW +: DW]  = cdata[i];
        end
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, drive next inputs.
    task automatic cycle();
        int unsigned   w;
        int unsigned   c;
        bit            found;
        logic [N-1:0]  eg;
        @(negedge clk);
        eg = '0; found = 1'b0; w = 0;
        if (sb.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && pending[c] != 0) begin found = 1'b1; w = c; end
            end
        end
        if (found) eg[w] = 1'b1;
        check("child_ready", 64'(child_ready), 64'(eg));
        check("out_valid",   64'(out_valid),   64'(sb.size() != 0));
        check("fifo_count",  64'(fifo_count),  64'(sb.size()));
        check("xfer_count",  64'(xfer_count),  64'(m_xfer));
        if (sb.size() != 0) begin
            check("out_data", 64'(out_data), 64'(sb[0].data));
            check("out_idx",  64'(out_idx),  64'(sb[0].idx));
            if (out_ready) void'(sb.pop_front());
        end
        if (found) begin
            sb.push_back('{data: cdata[w], idx: 4'(w)});
            m_ptr = (w + 1) % N;
            if (m_xfer != '1) m_xfer = m_xfer + 1'b1;
            pending[w]--;
        end
        @(posedge clk); #1;
        if (found) cdata[w] = cdata[w] + 32'h0001_0000;
        drive_inputs();
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr  = 0;
        m_xfer = '0;
    endtask

    initial begin
        rst         = 1'b1;
        out_ready   = 1'b1;
        s_valid     = '0;
        s_data      = '0;
        s_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pending[i] = 0;
            cdata[i]   = 32'hC000_0000 | 32'(i);
        end
        cdata[3] = 32'hA5A5_0003;
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_data",    64'(out_data),    64'd0);
        check("rst_out_idx",     64'(out_idx),     64'd0);
        check("rst_fifo_count",  64'(fifo_count),  64'd0);
        check("rst_xfer_count",  64'(xfer_count),  64'd0);
        check("rst_child_ready", 64'(child_ready), 64'd0);

        // Single word from child 3, one-cycle latency to the output.
        pending[3] = 1;
        drive_inputs();
        cycle();
        check("t1_out_data", 64'(out_data), 64'hA5A5_0003);
        check("t1_out_idx",  64'(out_idx),  64'd3);
        repeat (2) cycle();

        // All children valid: sustained one word per cycle in round-robin order.
        for (int i = 0; i < N; i++) pending[i] = 100;
        drive_inputs();
        repeat (17) cycle();
        check("t2_xfer_17", 64'(xfer_count), 64'd18);
        for (int i = 0; i < N; i++) pending[i] = 0;
        drive_inputs();
        repeat (3) cycle();

        // Fill with out_ready low, then release while full.
        out_ready = 1'b0;
        pending[2] = 1; pending[5] = 1; pending[9] = 1;
        pending[11] = 1; pending[13] = 1; pending[14] = 1;
        drive_inputs();
        repeat (5) cycle();
        check("t3_full_count", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        cycle();
        repeat (8) cycle();

        // Steady push+pop at occupancy 2 across several pointer wraps.
        out_ready  = 1'b0;
        pending[0] = 2;
        drive_inputs();
        repeat (2) cycle();
        out_ready  = 1'b1;
        pending[0] = 12;
        drive_inputs();
        repeat (12) cycle();
        check("t4_count_held", 64'(fifo_count), 64'd2);
        repeat (4) cycle();

        // Reset mid-operation with three words held.
        out_ready  = 1'b0;
        pending[4] = 3;
        drive_inputs();
        repeat (3) cycle();
        check("t5_pre_count", 64'(fifo_count), 64'd3);
        rst        = 1'b1;
        pending[4] = 0;
        pending[0] = 1;
        pending[7] = 1;
        drive_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("t5_out_valid",  64'(out_valid),  64'd0);
        check("t5_fifo_count", 64'(fifo_count), 64'd0);
        check("t5_xfer_count", 64'(xfer_count), 64'd0);
        check("t5_ready_c0",   64'(child_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) cycle();

        // Narrow transfer counter saturates at 15.
        s_valid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t6_ready", 64'(s_ready[0]), 64'd1);
            check("t6_xfer",  64'(s_xfer),     64'((k < 15) ? k : 15));
            @(posedge clk);
        end
        #1 s_valid[0] = 1'b0;
        check("t6_xfer_sat", 64'(s_xfer), 64'd15);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
